// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming-distance accumulator slice:
// FSM state encoding, default sizing constants and a ceil-log2 helper.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_MAX_WORDS = 16;

  // Number of bits needed to represent values 0 .. v-1 (ceil(log2(v))).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_accum_popcount.sv
// Combinational population count of one difference vector.
module popcount_w
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned POP_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [POP_W-1:0] count
);

  // Sum the individual bits of the vector.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + POP_W'(bits[i]);
    end
  end

endmodule

// File: rtl/hamming_accum.sv
// Frame-level Hamming distance accumulator. Sums popcount(diff) over a
// frame of XOR difference vectors, counts the words, and presents the
// result with an all-equal and a truncation flag on a valid/ready output.
module hamming_accum
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS,
  parameter int unsigned CNT_W     = clog2(MAX_WORDS + 1),
  parameter int unsigned SUM_W     = clog2(WIDTH * MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] diff,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] distance,
  output logic [CNT_W-1:0] word_count,
  output logic             equal,
  output logic             truncated
);

  localparam int unsigned POP_W = clog2(WIDTH + 1);

  state_t             state;
  logic [POP_W-1:0]   pop;
  logic [SUM_W-1:0]   sum_q;
  logic [CNT_W-1:0]   count_q;
  logic [SUM_W-1:0]   sum_next;
  logic [CNT_W-1:0]   count_next;
  logic               accept;
  logic               hit_max;

  popcount_w #(
    .WIDTH (WIDTH),
    .POP_W (POP_W)
  ) u_popcount (
    .bits  (diff),
    .count (pop)
  );

  // Next accumulator/counter values; IDLE starts a fresh frame from zero.
  always_comb begin
    accept     = in_valid & in_ready;
    sum_next   = ((state == ACC) ? sum_q : '0) + SUM_W'(pop);
    count_next = ((state == ACC) ? count_q : '0) + CNT_W'(1);
    hit_max    = (count_next == CNT_W'(MAX_WORDS));
  end

  // Frame FSM with accumulator, word counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sum_q     <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      equal     <= 1'b0;
      truncated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sum_q   <= sum_next;
            count_q <= count_next;
            if (in_last) begin
              state     <= DONE;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              equal     <= (sum_next == '0);
              truncated <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            sum_q   <= sum_next;
            count_q <= count_next;
            if (in_last || hit_max) begin
              state     <= DONE;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              equal     <= (sum_next == '0);
              truncated <= hit_max & ~in_last;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            sum_q     <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            equal     <= 1'b0;
            truncated <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign distance   = sum_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_hamming_accum.sv
// Directed self-checking bench for hamming_accum.
module tb_hamming_accum;

  logic       clk;
  logic       reset;
  logic [3:0] diff;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] distance;
  logic [4:0] word_count;
  logic       equal;
  logic       truncated;

  int checks;
  int errors;

  hamming_accum #(
    .WIDTH     (4),
    .MAX_WORDS (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .diff       (diff),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .distance   (distance),
    .word_count (word_count),
    .equal      (equal),
    .truncated  (truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it is accepted (bounded wait).
  task automatic send_word(input logic [3:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    diff     = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
    diff     = 4'bxxxx;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, distance, word_count, equal, truncated} !== {1'b0, 1'b1, 7'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_drain: ov=%b ir=%b dist=%0d wc=%0d eq=%b tr=%b, required ov=0 ir=1 dist=0 wc=0 eq=0 tr=0",
               name, out_valid, in_ready, distance, word_count, equal, truncated);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; diff = 4'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({out_valid, in_ready, distance, word_count, equal, truncated} !== {1'b0, 1'b1, 7'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ov=%b ir=%b dist=%0d wc=%0d eq=%b tr=%b, required ov=0 ir=1 dist=0 wc=0 eq=0 tr=0",
               out_valid, in_ready, distance, word_count, equal, truncated);
    end
  endtask

  task automatic test_single();
    send_word(4'b0011, 1'b1);
    checks++;
    if ({out_valid, in_ready, distance, word_count, equal, truncated} !== {1'b1, 1'b0, 7'd2, 5'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single: ov=%b ir=%b dist=%0d wc=%0d eq=%b tr=%b, required ov=1 ir=0 dist=2 wc=1 eq=0 tr=0",
               out_valid, in_ready, distance, word_count, equal, truncated);
    end
    drain("single");
  endtask

  task automatic test_multi();
    send_word(4'b1111, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_midframe: out_valid=%b, required 0", out_valid);
    end
    send_word(4'b0000, 1'b0);
    send_word(4'b1010, 1'b1);
    checks++;
    if ({out_valid, distance, word_count, equal, truncated} !== {1'b1, 7'd6, 5'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL multi: ov=%b dist=%0d wc=%0d eq=%b tr=%b, required ov=1 dist=6 wc=3 eq=0 tr=0",
               out_valid, distance, word_count, equal, truncated);
    end
    drain("multi");
  endtask

  task automatic test_hold();
    send_word(4'b0000, 1'b0);
    send_word(4'b0000, 1'b1);
    checks++;
    if ({out_valid, distance, word_count, equal} !== {1'b1, 7'd0, 5'd2, 1'b1}) begin
      errors++;
      $display("FAIL equal: ov=%b dist=%0d wc=%0d eq=%b, required ov=1 dist=0 wc=2 eq=1",
               out_valid, distance, word_count, equal);
    end
    // Offer a word while the result is pending; it must be neither taken nor counted.
    in_valid = 1'b1; diff = 4'b1111; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, distance, word_count, equal} !== {1'b0, 1'b1, 7'd0, 5'd2, 1'b1}) begin
        errors++;
        $display("FAIL hold_c%0d: ir=%b ov=%b dist=%0d wc=%0d eq=%b, required ir=0 ov=1 dist=0 wc=2 eq=1",
                 i, in_ready, out_valid, distance, word_count, equal);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, word_count} !== {1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL hold_release: ov=%b ir=%b wc=%0d, required ov=0 ir=1 wc=0",
               out_valid, in_ready, word_count);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0; diff = 4'bxxxx;
    checks++;
    if ({out_valid, distance, word_count, equal} !== {1'b1, 7'd4, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL hold_next: ov=%b dist=%0d wc=%0d eq=%b, required ov=1 dist=4 wc=1 eq=0",
               out_valid, distance, word_count, equal);
    end
    drain("hold");
  endtask

  task automatic test_truncate();
    for (int i = 0; i < 16; i++) begin
      send_word(4'b1111, 1'b0);
      if (i == 14) begin
        checks++;
        if ({out_valid, word_count} !== {1'b0, 5'd15}) begin
          errors++;
          $display("FAIL trunc_15: ov=%b wc=%0d, required ov=0 wc=15", out_valid, word_count);
        end
      end
    end
    checks++;
    if ({out_valid, distance, word_count, equal, truncated} !== {1'b1, 7'd64, 5'd16, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL truncate: ov=%b dist=%0d wc=%0d eq=%b tr=%b, required ov=1 dist=64 wc=16 eq=0 tr=1",
               out_valid, distance, word_count, equal, truncated);
    end
    drain("truncate");
    send_word(4'b0001, 1'b1);
    checks++;
    if ({out_valid, distance, word_count, truncated} !== {1'b1, 7'd1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL trunc_17th: ov=%b dist=%0d wc=%0d tr=%b, required ov=1 dist=1 wc=1 tr=0",
               out_valid, distance, word_count, truncated);
    end
    drain("trunc_17th");
  endtask

  task automatic test_last_at_max();
    for (int i = 0; i < 15; i++) send_word(4'b0001, 1'b0);
    send_word(4'b0001, 1'b1);
    checks++;
    if ({out_valid, distance, word_count, truncated} !== {1'b1, 7'd16, 5'd16, 1'b0}) begin
      errors++;
      $display("FAIL last_at_max: ov=%b dist=%0d wc=%0d tr=%b, required ov=1 dist=16 wc=16 tr=0",
               out_valid, distance, word_count, truncated);
    end
    drain("last_at_max");
  endtask

  task automatic test_out_ready_ignored();
    send_word(4'b0110, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, distance, word_count} !== {1'b0, 1'b1, 7'd2, 5'd1}) begin
      errors++;
      $display("FAIL oready_ignored: ov=%b ir=%b dist=%0d wc=%0d, required ov=0 ir=1 dist=2 wc=1",
               out_valid, in_ready, distance, word_count);
    end
    tick(); tick();
    send_word(4'b1000, 1'b1);
    checks++;
    if ({out_valid, distance, word_count} !== {1'b1, 7'd3, 5'd2}) begin
      errors++;
      $display("FAIL gap_frame: ov=%b dist=%0d wc=%0d, required ov=1 dist=3 wc=2",
               out_valid, distance, word_count);
    end
    drain("gap_frame");
  endtask

  task automatic test_reset_mid();
    send_word(4'b1111, 1'b0);
    send_word(4'b0111, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({out_valid, in_ready, distance, word_count} !== {1'b0, 1'b1, 7'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_mid: ov=%b ir=%b dist=%0d wc=%0d, required ov=0 ir=1 dist=0 wc=0",
               out_valid, in_ready, distance, word_count);
    end
    send_word(4'b0001, 1'b1);
    checks++;
    if ({out_valid, distance, word_count} !== {1'b1, 7'd1, 5'd1}) begin
      errors++;
      $display("FAIL after_reset_mid: ov=%b dist=%0d wc=%0d, required ov=1 dist=1 wc=1",
               out_valid, distance, word_count);
    end
    // Reset while a result is pending discards it.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({out_valid, in_ready, distance, word_count} !== {1'b0, 1'b1, 7'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_done: ov=%b ir=%b dist=%0d wc=%0d, required ov=0 ir=1 dist=0 wc=0",
               out_valid, in_ready, distance, word_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_multi();
    test_hold();
    test_truncate();
    test_last_at_max();
    test_out_ready_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
